dm_cache_responder: RTL
=======================

// Module: dm_cache_responder
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate cache; the responder side of the driver<->cache
//  request interface used by the lab04 cache test driver. Accepts one read/write request at a time,
//  answers hits from on-chip line storage and refills misses from a main-memory port with a
//  req/ready handshake. Sits between the access driver (initiator) and the trace/main memory model.
// PARAMETERS
//  ADDR_W    13  byte address width (tag = ADDR_W-INDEX_W-OFFSET_W = 3 by default)
//  INDEX_W    6  line index bits -> 64 lines
//  OFFSET_W   4  byte offset in line -> 16-byte lines, 4 x 32-bit words
//  CNT_W     16  width of saturating performance counters
// PORTS
//  clk           in   1         system clock, all state on rising edge
//  resetn        in   1         asynchronous, active-low reset
//  cpu_req       in   1         request valid; sampled only while cpu_ready=1
//  cpu_wr        in   1         1=write, 0=read (qualified by cpu_req)
//  cpu_addr      in   ADDR_W    byte address, bits[1:0] ignored
//  cpu_wdata     in   32        write data
//  cpu_ready     out  1         1 in IDLE only
//  cpu_ack       out  1         one-cycle pulse: request complete
//  cpu_hit       out  1         valid with cpu_ack: lookup hit
//  cpu_rdata     out  32        read data, valid with cpu_ack for reads, held until next ack
//  mem_rd        out  1         line refill request, held until mem_ready
//  mem_wr        out  1         word write-through request, held until mem_ready
//  mem_addr      out  ADDR_W    line-aligned (refill) or word-aligned (write) address
//  mem_wdata     out  32        write-through data
//  mem_rdata     in   128       refill line, word0 in bits[31:0]; valid when mem_ready & mem_rd
//  mem_ready     in   1         memory completes current mem_rd/mem_wr this cycle
//  hit_count     out  CNT_W     saturating count of acked hits
//  access_count  out  CNT_W     saturating count of acked requests
// BEHAVIOUR
//  - Reset (async, resetn=0): state IDLE, all valid bits 0, cpu_ready=1, cpu_ack=0, cpu_hit=0,
//    cpu_rdata=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, counters 0. Tag/data arrays not reset.
//    Reset mid-refill/write abandons the memory transaction; memory model must tolerate the drop.
//  - States: IDLE -> LOOKUP -> {IDLE | REFILL | WTHRU}; REFILL -> RESP -> IDLE; WTHRU -> IDLE.
//  - IDLE: cpu_req=1 latches addr/wr/wdata, -> LOOKUP (cpu_ready=0 next cycle).
//  - LOOKUP: hit = valid[idx] & tag[idx]==addr tag.
//      read hit  : cpu_rdata<=word, cpu_ack=1, cpu_hit=1, -> IDLE. Latency 2 clk req->ack.
//      read miss : mem_rd=1, mem_addr={tag,idx,OFFSET_W'b0}, -> REFILL.
//      write     : mem_wr=1, mem_addr={addr[ADDR_W-1:2],2'b0}, mem_wdata=wdata; on hit the cached word
//                  is updated in the same edge; miss leaves cache untouched; -> WTHRU.
//  - REFILL: wait mem_ready; on it store line, tag, valid=1, drop mem_rd, -> RESP.
//  - RESP: cpu_rdata<=requested word of new line, cpu_ack=1, cpu_hit=0, -> IDLE.
//  - WTHRU: wait mem_ready; drop mem_wr, cpu_ack=1, cpu_hit=latched lookup result, -> IDLE.
//  - mem_rd and mem_wr never both 1; mem_ready while neither asserted is ignored.
//  - cpu_req while cpu_ready=0 is ignored (no queuing); driver must hold/reissue.
//  - Same-cycle mem_ready on entry edge not possible: mem_* asserted first, ready sampled from next clk.
//  - Counters update on cpu_ack; saturate at all-ones, no wrap.
// STRUCTURE
//  - Shared header cache_defs.vh: state encodings (IDLE=0..RESP=4), default widths, WORDS_PER_LINE.
//  - Sub-module cache_line_store: valid/tag/data arrays; 1 combinational read port, 1 write port
//    (full-line refill or single-word update with word select); async clear of valid bits.
//  - Top: FSM, request latch, mem handshake, counters.
// TESTING
//  1. Reset, read 0x0000 -> mem_rd at 0x0000, reply line {4,3,2,1} after 3 clk -> ack, hit=0, rdata=1.
//  2. Then read 0x0008 -> ack exactly 2 clk after req, hit=1, rdata=3, no mem_rd; hit_count=1.
//  3. Write 0x0004=0xDEADBEEF -> mem_wr addr 0x0004, ack hit=1; read 0x0004 -> hit, 0xDEADBEEF.
//  4. Write 0x1F00 (miss) -> mem_wr only, hit=0; read 0x1F00 -> miss + refill (no allocate).
//  5. Conflict: read 0x0000 then 0x0400 (same idx, tag differ) then 0x0000 -> miss,miss,miss.
//  6. resetn low during REFILL wait -> mem_rd=0 immediately, cpu_ready=1; re-read 0x0000 misses.

Source files
------------

// File: rtl/dm_cache_responder_pkg.sv
// Shared types and default geometry for the direct-mapped write-through cache responder.
package dm_cache_responder_pkg;

  localparam int DEF_ADDR_W   = 13;
  localparam int DEF_INDEX_W  = 6;
  localparam int DEF_OFFSET_W = 4;
  localparam int DEF_CNT_W    = 16;
  localparam int WORD_W       = 32;
  localparam int DEF_WORDS_PER_LINE = 1 << (DEF_OFFSET_W - 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_REFILL = 3'd2,
    S_WTHRU  = 3'd3,
    S_RESP   = 3'd4
  } state_t;

endpackage

// File: rtl/dm_cache_responder_line_store.sv
// Valid/tag/data storage: one combinational read port, one write port (full line or single word).
module dm_cache_responder_line_store
  import dm_cache_responder_pkg::*;
#(
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int TAG_W   = DEF_ADDR_W - DEF_INDEX_W - DEF_OFFSET_W,
  parameter int WSEL_W  = DEF_OFFSET_W - 2,
  parameter int WORDS   = 1 << WSEL_W
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [INDEX_W-1:0]            rd_idx,
  output logic                          rd_valid,
  output logic [TAG_W-1:0]              rd_tag,
  output logic [WORDS-1:0][WORD_W-1:0]  rd_line,
  input  logic                          line_we,
  input  logic                          word_we,
  input  logic [INDEX_W-1:0]            wr_idx,
  input  logic [TAG_W-1:0]              wr_tag,
  input  logic [WSEL_W-1:0]             wr_sel,
  input  logic [WORDS-1:0][WORD_W-1:0]  wr_line,
  input  logic [WORD_W-1:0]             wr_word
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem [LINES];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      valid         <= '0;
    else if (line_we) valid[wr_idx] <= 1'b1;
  end

  // Tags only change on refill; a word update never retags a line.
  always_ff @(posedge clk) begin
    if (line_we) tag_mem[wr_idx] <= wr_tag;
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];

  for (genvar w = 0; w < WORDS; w++) begin : g_bank
    logic [WORD_W-1:0] bank [LINES];
    logic              we;

    assign we = line_we || (word_we && (wr_sel == WSEL_W'(w)));

    always_ff @(posedge clk) begin
      if (we) bank[wr_idx] <= line_we ? wr_line[w] : wr_word;
    end

    assign rd_line[w] = bank[rd_idx];
  end

endmodule

// File: rtl/dm_cache_responder.sv
// Direct-mapped, write-through, no-write-allocate cache: request FSM, memory handshake, counters.
module dm_cache_responder
  import dm_cache_responder_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int INDEX_W  = DEF_INDEX_W,
  parameter int OFFSET_W = DEF_OFFSET_W,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         cpu_req,
  input  logic                         cpu_wr,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [31:0]                  cpu_wdata,
  output logic                         cpu_ready,
  output logic                         cpu_ack,
  output logic                         cpu_hit,
  output logic [31:0]                  cpu_rdata,
  output logic                         mem_rd,
  output logic                         mem_wr,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [31:0]                  mem_wdata,
  input  logic [32*(1<<(OFFSET_W-2))-1:0] mem_rdata,
  input  logic                         mem_ready,
  output logic [CNT_W-1:0]             hit_count,
  output logic [CNT_W-1:0]             access_count
);

  localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WSEL_W = OFFSET_W - 2;
  localparam int WORDS  = 1 << WSEL_W;

  state_t                      state;
  logic [ADDR_W-3:0]           addr_q;   // word address; byte lane bits are never used
  logic                        wr_q;
  logic [31:0]                 wdata_q;
  logic                        hit_q;

  logic [TAG_W-1:0]            tag_q;
  logic [INDEX_W-1:0]          idx_q;
  logic [WSEL_W-1:0]           sel_q;
  logic                        rd_valid;
  logic [TAG_W-1:0]            rd_tag;
  logic [WORDS-1:0][31:0]      rd_line;
  logic                        hit;
  logic                        line_we;
  logic                        word_we;

  wire unused_byte_lane = ^cpu_addr[1:0];

  assign tag_q = addr_q[ADDR_W-3 -: TAG_W];
  assign idx_q = addr_q[WSEL_W +: INDEX_W];
  assign sel_q = addr_q[WSEL_W-1:0];

  assign hit     = rd_valid && (rd_tag == tag_q);
  assign line_we = (state == S_REFILL) && mem_ready;
  assign word_we = (state == S_LOOKUP) && wr_q && hit;

  dm_cache_responder_line_store #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .WSEL_W  (WSEL_W),
    .WORDS   (WORDS)
  ) u_store (
    .clk      (clk),
    .resetn   (resetn),
    .rd_idx   (idx_q),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .line_we  (line_we),
    .word_we  (word_we),
    .wr_idx   (idx_q),
    .wr_tag   (tag_q),
    .wr_sel   (sel_q),
    .wr_line  (mem_rdata),
    .wr_word  (wdata_q)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      wdata_q      <= '0;
      hit_q        <= 1'b0;
      cpu_ready    <= 1'b1;
      cpu_ack      <= 1'b0;
      cpu_hit      <= 1'b0;
      cpu_rdata    <= '0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      hit_count    <= '0;
      access_count <= '0;
    end else begin
      cpu_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            addr_q    <= cpu_addr[ADDR_W-1:2];
            wr_q      <= cpu_wr;
            wdata_q   <= cpu_wdata;
            cpu_ready <= 1'b0;
            state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          hit_q <= hit;
          if (wr_q) begin
            // Write-through regardless of hit; the store updates the cached word on this edge.
            mem_wr    <= 1'b1;
            mem_addr  <= {addr_q, 2'b00};
            mem_wdata <= wdata_q;
            state     <= S_WTHRU;
          end else if (hit) begin
            cpu_rdata    <= rd_line[sel_q];
            cpu_ack      <= 1'b1;
            cpu_hit      <= 1'b1;
            cpu_ready    <= 1'b1;
            hit_count    <= sat_inc(hit_count);
            access_count <= sat_inc(access_count);
            state        <= S_IDLE;
          end else begin
            mem_rd   <= 1'b1;
            mem_addr <= {tag_q, idx_q, {OFFSET_W{1'b0}}};
            state    <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (mem_ready) begin
            mem_rd <= 1'b0;
            state  <= S_RESP;
          end
        end
        S_RESP: begin
          cpu_rdata    <= rd_line[sel_q];
          cpu_ack      <= 1'b1;
          cpu_hit      <= 1'b0;
          cpu_ready    <= 1'b1;
          access_count <= sat_inc(access_count);
          state        <= S_IDLE;
        end
        S_WTHRU: begin
          if (mem_ready) begin
            mem_wr       <= 1'b0;
            cpu_ack      <= 1'b1;
            cpu_hit      <= hit_q;
            cpu_ready    <= 1'b1;
            access_count <= sat_inc(access_count);
            if (hit_q) hit_count <= sat_inc(hit_count);
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
